// File: rtl/opb_qdr_ctrl_pkg.sv
// Shared definitions for the OPB QDR control/status slave.
//   Register word indices, STATUS field offsets, error-counter geometry and a
//   byte-enable to bit-mask helper.
// Optional feature macro used by the design: QDR_CTRL_ERRCNT_EN.
package opb_qdr_ctrl_pkg;

  // Register word indices (address offset bits [5:2]).
  localparam logic [3:0] WordCtrl      = 4'd0;
  localparam logic [3:0] WordRstLen    = 4'd1;
  localparam logic [3:0] WordStatus    = 4'd2;
  localparam logic [3:0] WordStickyClr = 4'd3;

  // STATUS field offsets.
  localparam int unsigned StatusPhyRdyOff  = 0;
  localparam int unsigned StatusCalFailOff = 8;
  localparam int unsigned StatusStickyOff  = 16;

  // Per-channel phy_rdy drop counters (optional feature).
  localparam int unsigned ErrCntW    = 16;
  localparam int unsigned ErrCntBase = 4;

  // be[0] is the byte lane of register bits 7:0 (OPB_BE[3] in big-endian terms).
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/qdr_rst_pulse.sv
// Per-channel reset pulse generator.
//   clk     : clock
//   rst     : synchronous active-high reset, clears the counter
//   trigger : load the counter with max(len, 1); reloads when already busy
//   len     : pulse length in cycles
//   busy    : a pulse is in progress
//   rst_out : reset output, high for exactly the loaded number of cycles
module qdr_rst_pulse #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trigger,
  input  logic [CntW-1:0] len,
  output logic            busy,
  output logic            rst_out
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (trigger) begin
      cnt_d = (len == '0) ? CntW'(1) : len;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign rst_out = busy;

endmodule

// File: rtl/opb_qdr_ctrl.sv
// OPB control/status slave for NUM_QDR QDR SRAM controllers (single clock OPB_Clk).
// Ports:
//   OPB_Clk, OPB_Rst          clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW      OPB request (big-endian bit numbering; vector value = register value)
//   OPB_select, OPB_seqAddr   transfer request, burst hint (ignored)
//   Sl_DBus, Sl_xferAck       read data (zero outside ack) and one-cycle transfer ack
//   Sl_errAck/retry/toutSup   tied low
//   phy_rdy, cal_fail         asynchronous per-channel status inputs
//   qdr_reset                 per-channel active-high reset
// Words: 0 CTRL, 1 RST_LEN, 2 STATUS, 3 STICKY_CLR.
// Define QDR_CTRL_ERRCNT_EN to add read-only phy_rdy drop counters at words 4..4+NUM_QDR-1.
module opb_qdr_ctrl
  import opb_qdr_ctrl_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR      = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR      = 32'h0000_00FF,
  parameter int unsigned C_OPB_AWIDTH    = 32,
  parameter int unsigned C_OPB_DWIDTH    = 32,
  parameter int unsigned NUM_QDR         = 2,
  parameter int unsigned RST_CNT_W       = 8,
  parameter int unsigned RST_LEN_DEFAULT = 16,
  parameter int unsigned AUTO_RST        = 1
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [NUM_QDR-1:0]          phy_rdy,
  input  logic [NUM_QDR-1:0]          cal_fail,
  output logic [NUM_QDR-1:0]          qdr_reset
);

  localparam logic                 AutoRst    = (AUTO_RST != 0);
  localparam logic [RST_CNT_W-1:0] RstLenInit = RST_CNT_W'(RST_LEN_DEFAULT);

  logic [C_OPB_AWIDTH-1:0] addr, offset;
  logic [31:0]             wdata;
  logic [3:0]              word_idx;
  logic                    hit, req;

  logic                    ack_q;
  logic [31:0]             rdata_q, rdata_mux;
  logic                    wr_q;
  logic [3:0]              wr_idx_q;
  logic [31:0]             wr_data_q, wr_mask_q;

  logic [RST_CNT_W-1:0]    rst_len_q, rst_len_d;
  logic [NUM_QDR-1:0]      phy_rdy_m_q, phy_rdy_s_q, cal_fail_m_q, cal_fail_s_q;
  logic [NUM_QDR-1:0]      sticky_q, sticky_d, sticky_clr;
  logic [NUM_QDR-1:0]      ctrl_trig, trig, busy, pulse;
  logic                    auto_q;

  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign offset   = addr - C_OPB_AWIDTH'(C_BASEADDR);
  assign word_idx = offset[5:2];
  assign hit      = OPB_select && (addr >= C_OPB_AWIDTH'(C_BASEADDR)) &&
                    (addr < C_OPB_AWIDTH'(C_HIGHADDR));
  // A new request is only accepted when no ack is pending, giving one ack per access.
  assign req      = hit && !ack_q;

  assign Sl_xferAck = ack_q;
  assign Sl_DBus    = rdata_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

`ifdef QDR_CTRL_ERRCNT_EN
  logic [NUM_QDR-1:0] phy_rdy_p_q;
  logic [ErrCntW-1:0] errcnt_q [NUM_QDR];
  logic [ErrCntW-1:0] errcnt_d [NUM_QDR];

  always_comb begin
    for (int i = 0; i < NUM_QDR; i++) begin
      errcnt_d[i] = errcnt_q[i];
      // Clear wins over a same-cycle increment.
      if (wr_q && (wr_idx_q == 4'(ErrCntBase + i))) begin
        errcnt_d[i] = '0;
      end else if (phy_rdy_p_q[i] && !phy_rdy_s_q[i] && (errcnt_q[i] != '1)) begin
        errcnt_d[i] = errcnt_q[i] + ErrCntW'(1);
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      phy_rdy_p_q <= '0;
      for (int i = 0; i < NUM_QDR; i++) errcnt_q[i] <= '0;
    end else begin
      phy_rdy_p_q <= phy_rdy_s_q;
      for (int i = 0; i < NUM_QDR; i++) errcnt_q[i] <= errcnt_d[i];
    end
  end
`endif

  // Read data mux, evaluated in the request cycle and registered into the ack cycle.
  always_comb begin
    rdata_mux = '0;
    case (word_idx)
      WordCtrl:   rdata_mux[NUM_QDR-1:0] = busy;
      WordRstLen: rdata_mux[RST_CNT_W-1:0] = rst_len_q;
      WordStatus: begin
        rdata_mux[StatusPhyRdyOff  +: NUM_QDR] = phy_rdy_s_q;
        rdata_mux[StatusCalFailOff +: NUM_QDR] = cal_fail_s_q;
        rdata_mux[StatusStickyOff  +: NUM_QDR] = sticky_q;
      end
      default: begin
`ifdef QDR_CTRL_ERRCNT_EN
        for (int i = 0; i < NUM_QDR; i++) begin
          if (word_idx == 4'(ErrCntBase + i)) rdata_mux[ErrCntW-1:0] = errcnt_q[i];
        end
`endif
      end
    endcase
  end

  // Write side effects commit at the end of the ack cycle from the captured request.
  always_comb begin
    ctrl_trig  = '0;
    sticky_clr = '0;
    rst_len_d  = rst_len_q;
    if (wr_q) begin
      case (wr_idx_q)
        WordCtrl:      ctrl_trig  = wr_data_q[NUM_QDR-1:0] & wr_mask_q[NUM_QDR-1:0];
        WordRstLen:    rst_len_d  = (rst_len_q & ~wr_mask_q[RST_CNT_W-1:0]) |
                                    (wr_data_q[RST_CNT_W-1:0] & wr_mask_q[RST_CNT_W-1:0]);
        WordStickyClr: sticky_clr = wr_data_q[NUM_QDR-1:0] & wr_mask_q[NUM_QDR-1:0];
        default: ;
      endcase
    end
    // A fresh failure beats a same-cycle clear.
    sticky_d = (sticky_q & ~sticky_clr) | cal_fail_s_q;
    // auto_q marks the first cycle after OPB_Rst: every channel pulses with the default length.
    trig     = ctrl_trig | {NUM_QDR{auto_q}};
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      wr_q         <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      rst_len_q    <= RstLenInit;
      phy_rdy_m_q  <= '0;
      phy_rdy_s_q  <= '0;
      cal_fail_m_q <= '0;
      cal_fail_s_q <= '0;
      sticky_q     <= '0;
      auto_q       <= AutoRst;
    end else begin
      ack_q        <= req;
      rdata_q      <= (req && OPB_RNW) ? rdata_mux : '0;
      wr_q         <= req && !OPB_RNW;
      if (req) begin
        wr_idx_q  <= word_idx;
        wr_data_q <= wdata;
        wr_mask_q <= be_to_mask(OPB_BE);
      end
      rst_len_q    <= rst_len_d;
      phy_rdy_m_q  <= phy_rdy;
      phy_rdy_s_q  <= phy_rdy_m_q;
      cal_fail_m_q <= cal_fail;
      cal_fail_s_q <= cal_fail_m_q;
      sticky_q     <= sticky_d;
      auto_q       <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_QDR; g++) begin : g_chan
    qdr_rst_pulse #(
      .CntW (RST_CNT_W)
    ) u_pulse (
      .clk     (OPB_Clk),
      .rst     (OPB_Rst),
      .trigger (trig[g]),
      .len     (rst_len_q),
      .busy    (busy[g]),
      .rst_out (pulse[g])
    );
  end

  // During OPB_Rst the channels are held in reset when auto-reset is enabled, else released.
  assign qdr_reset = AutoRst ? (pulse | {NUM_QDR{OPB_Rst}}) : (pulse & ~{NUM_QDR{OPB_Rst}});

  logic unused_bits;
  assign unused_bits = ^{OPB_seqAddr, offset, wr_data_q, wr_mask_q};

endmodule

// File: tb/tb_opb_qdr_ctrl.sv
module tb_opb_qdr_ctrl;

  localparam int N = 2;

  logic          OPB_Clk = 1'b0;
  logic          OPB_Rst;
  logic [0:31]   OPB_ABus, OPB_DBus, Sl_DBus;
  logic [0:3]    OPB_BE;
  logic          OPB_RNW, OPB_select, OPB_seqAddr;
  logic          Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [N-1:0]  phy_rdy, cal_fail, qdr_reset;

  opb_qdr_ctrl #(.NUM_QDR(N)) dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst     (OPB_Rst),
    .OPB_ABus    (OPB_ABus),
    .OPB_BE      (OPB_BE),
    .OPB_DBus    (OPB_DBus),
    .OPB_RNW     (OPB_RNW),
    .OPB_select  (OPB_select),
    .OPB_seqAddr (OPB_seqAddr),
    .Sl_DBus     (Sl_DBus),
    .Sl_xferAck  (Sl_xferAck),
    .Sl_errAck   (Sl_errAck),
    .Sl_retry    (Sl_retry),
    .Sl_toutSup  (Sl_toutSup),
    .phy_rdy     (phy_rdy),
    .cal_fail    (cal_fail),
    .qdr_reset   (qdr_reset)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  int nvec = 0;
  int nerr = 0;

  // Cycle k (1-based) starts at the k-th rising edge; qdr_reset is recorded 1 ns into it.
  int           cyc = 0;
  logic [N-1:0] hist[$];
  always @(posedge OPB_Clk) begin
    #1;
    cyc = cyc + 1;
    hist.push_back(qdr_reset);
  end

  // Reference model: a trigger committed in cycle a with length L drives the channel high in
  // cycles a+1 .. a+L; the latest trigger on a channel decides. Reset cycles force all high.
  typedef struct { int a; int len; logic [N-1:0] mask; } trig_t;
  trig_t trigs[$];
  int    rst_lo[$], rst_hi[$];
  int    m_len;
  logic [N-1:0] m_sticky;
  int    last_ack;

  function automatic logic [N-1:0] model_rst(input int t);
    logic [N-1:0] r = '0;
    bit in_rst = 0;
    for (int k = 0; k < rst_lo.size(); k++)
      if (t >= rst_lo[k] && t <= rst_hi[k]) in_rst = 1;
    for (int ch = 0; ch < N; ch++) begin
      int la = -1, ll = 0;
      for (int k = 0; k < trigs.size(); k++)
        if (trigs[k].mask[ch] && trigs[k].a < t) begin la = trigs[k].a; ll = trigs[k].len; end
      r[ch] = in_rst || (la >= 0 && t <= la + ll);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge OPB_Clk); #2; end
  endtask

  task automatic bus(input logic [31:0] a, input logic rnw, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rd, output int ac, output bit got);
    OPB_ABus = a; OPB_RNW = rnw; OPB_DBus = d; OPB_BE = be; OPB_select = 1'b1;
    got = 0; rd = '0; ac = -1;
    for (int n = 0; n < 4; n++) begin
      @(posedge OPB_Clk); #2;
      if (Sl_xferAck === 1'b1) begin got = 1; rd = Sl_DBus; ac = cyc; break; end
    end
    OPB_select = 1'b0; OPB_RNW = 1'b1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] rd; int ac; bit got;
    bus(32'(idx * 4), 1'b0, d, be, rd, ac, got);
    check("wr_ack", {31'b0, got}, 32'd1);
    check("wr_dbus_zero", rd, 32'd0);
    last_ack = ac;
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    int ac; bit got;
    bus(32'(idx * 4), 1'b1, 32'hDEAD_BEEF, 4'hF, d, ac, got);
    check("rd_ack", {31'b0, got}, 32'd1);
    last_ack = ac;
  endtask

  task automatic trigger(input logic [N-1:0] mask, input logic [31:0] junk);
    trig_t tr;
    wr(0, (junk & ~32'(2**N - 1)) | 32'(mask), 4'hF);
    tr.a = last_ack; tr.len = (m_len == 0) ? 1 : m_len; tr.mask = mask;
    trigs.push_back(tr);
  endtask

  // Busy read reflects the request cycle; compare only where the model is steady.
  task automatic check_busy();
    logic [31:0] d; logic [N-1:0] e0, e1;
    rd(0, d);
    e0 = model_rst(last_ack - 1);
    e1 = model_rst(last_ack);
    if (e0 == e1) check("ctrl_busy", d, 32'(e0));
  endtask

  task automatic reset_pulse(input int ncyc);
    trig_t tr;
    int lo;
    lo = cyc + 1;
    OPB_Rst = 1'b1;
    idle(ncyc);
    OPB_Rst = 1'b0;
    rst_lo.push_back(lo); rst_hi.push_back(cyc);
    tr.a = cyc; tr.len = 16; tr.mask = '1;
    trigs.push_back(tr);
    m_len = 16; m_sticky = '0;
  endtask

  initial begin
    logic [31:0] d, exp_st;
    logic [3:0]  be;
    logic [N-1:0] p;
    int          w;
    trig_t       tr;

    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_DBus = '0; OPB_BE = '0; OPB_RNW = 1'b1;
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; phy_rdy = '0; cal_fail = '0;
    idle(4);
    OPB_Rst = 1'b0;
    rst_lo.push_back(1); rst_hi.push_back(cyc);
    tr.a = cyc; tr.len = 16; tr.mask = '1;
    trigs.push_back(tr);
    m_len = 16; m_sticky = '0;

    // Reset state.
    rd(1, d); check("rst_len_default", d, 32'd16);
    rd(2, d); check("status_reset", d, 32'd0);
    check_busy();
    idle(20);

    // Directed pulse of 5, then re-trigger with 3 cycles left.
    wr(1, 32'd5, 4'hF); m_len = 5;
    trigger(2'b01, 32'd0);
    idle(2);
    trigger(2'b01, 32'd0);
    rd(0, d); check("ctrl_busy_mid", d, 32'd1);
    idle(10);

    // Zero length behaves as one.
    wr(1, 32'd0, 4'hF); m_len = 0;
    trigger(2'b10, 32'd0);
    idle(4);

    // Randomised lengths, byte enables, channel masks and re-trigger spacing.
    for (int it = 0; it < 10; it++) begin
      d  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 24));
      be = 4'($urandom_range(0, 15));
      wr(1, d, be);
      if (be[0]) m_len = int'(d[7:0]);
      rd(1, d); check("rst_len_rb", d, 32'(m_len));
      trigger(N'($urandom_range(1, 3)), $urandom);
      idle($urandom_range(0, 20));
      check_busy();
      phy_rdy = N'($urandom);
    end
    idle(30);

    // Status synchronisers and sticky flags.
    p = N'($urandom); phy_rdy = p;
    cal_fail = 2'b10; idle(1); cal_fail = '0;
    idle(5);
    m_sticky = 2'b10;
    exp_st = 32'(p) | (32'(m_sticky) << 16);
    rd(2, d); check("status_sticky_set", d, exp_st);
    wr(3, 32'h2, 4'hE);
    rd(2, d); check("sticky_clr_be_off", d, exp_st);
    wr(3, 32'h2, 4'hF); m_sticky = '0;
    rd(2, d); check("status_sticky_clr", d, 32'(p));
    rd(3, d); check("sticky_clr_reads0", d, 32'd0);
    cal_fail = 2'b10; idle(4);
    wr(3, 32'h2, 4'hF);
    rd(2, d); check("sticky_set_beats_clr", d, 32'(p) | 32'h0002_0200);
    cal_fail = '0; idle(4);
    rd(2, d); check("sticky_holds", d, 32'(p) | 32'h0002_0000);
    wr(3, 32'h3, 4'hF);
    rd(2, d); check("sticky_cleared", d, 32'(p));

    // Unmapped words and decode boundaries.
    w = $urandom_range(6, 15);
    wr(w, $urandom, 4'hF);
    rd(w, d); check("unmapped_rd", d, 32'd0);
    rd(1, d); check("unmapped_wr_ignored", d, 32'(m_len));
`ifndef QDR_CTRL_ERRCNT_EN
    rd(4, d); check("word4_absent", d, 32'd0);
`endif
    begin
      int ac; bit got;
      bus(32'h100, 1'b1, 32'd0, 4'hF, d, ac, got);
      check("out_of_range_noack", {31'b0, got}, 32'd0);
    end
    OPB_ABus = 32'hFC; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge OPB_Clk); #2;
      check("b2b_ack", {31'b0, Sl_xferAck}, 32'(k % 2 == 0));
      check("b2b_dbus", Sl_DBus, 32'd0);
    end
    OPB_select = 1'b0;
    idle(2);

`ifdef QDR_CTRL_ERRCNT_EN
    phy_rdy = 2'b11; idle(4);
    wr(4, 32'd0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      phy_rdy[0] = 1'b0; idle(4);
      phy_rdy[0] = 1'b1; idle(4);
    end
    rd(4, d); check("errcnt0_three", d, 32'd3);
    wr(4, 32'hFFFF, 4'h1);
    rd(4, d); check("errcnt0_cleared", d, 32'd0);
`endif

    // Reset in the middle of a pulse.
    wr(1, 32'd20, 4'hF); m_len = 20;
    trigger(2'b11, 32'd0);
    idle(4);
    reset_pulse(2);
    rd(1, d); check("rst_len_after_rst", d, 32'd16);
    rd(2, d); check("status_after_rst", d, 32'(phy_rdy));
    idle(25);

    // Whole-run cycle-by-cycle comparison of qdr_reset against the model.
    for (int t = 1; t <= hist.size(); t++)
      check($sformatf("qdr_reset@%0d", t), 32'(hist[t-1]), 32'(model_rst(t)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
